uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO, configurable frame format (data bits, parity, stop bits), and overflow reporting. It sits between byte producers (e.g. SPI flash read path, test pattern generators) and the board UART pin. Producers issue single-cycle write strobes without waiting for the line to go idle. Queued characters go out back-to-back with no inter-frame gap.

---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a show-ahead FIFO.
// Producers push characters with single-cycle strobes. Queued characters go
// out back-to-back with no gap between frames.
// Ports:
//   sys_clk, sys_rst_n    clock, asynchronous active-low reset
//   pi_data, pi_flag      character to queue and its write strobe
//   tx                    serial line, idles high
//   busy                  high while a frame is being shifted out
//   fifo_full/fifo_empty  registered occupancy flags
//   fifo_cnt              registered occupancy, 0..FIFO_DEPTH
//   ovf                   one-cycle pulse when a write is dropped because the FIFO is full
module uart_tx_fifo #(
  parameter int unsigned UART_BPS   = 'd9600,
  parameter int unsigned CLK_FREQ   = 'd50_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [DATA_BITS-1:0]          pi_data,
  input  logic                          pi_flag,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = PTR_W + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t               state_q, state_d;
  logic [15:0]          baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic                 wr_en, pop, baud_end;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    wr_en      = pi_flag & ~full_q;
    baud_end   = (baud_cnt_q == 16'(BAUD_CNT_MAX - 1));
    baud_cnt_d = (state_q == ST_IDLE || baud_end) ? '0 : baud_cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = ST_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            // Shift right so the next data bit is always at position 1.
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            if (!empty_q) begin
              pop     = 1'b1;
              state_d = ST_START;
              tx_d    = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Parity is fixed at pop time so later shifting cannot disturb it.
    if (pop) begin
      shreg_d = head;
      par_d   = (PARITY == 2) ? ^head : ~^head;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
    full_d   = (cnt_d == CNT_W'(FIFO_DEPTH));
    empty_d  = (cnt_d == '0);
    ovf_d    = pi_flag & full_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pi_data;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_cnt   = cnt_q;
  assign ovf        = ovf_q;

endmodule
